// File: rtl/imm_pkg.sv
// Shared types and default widths for the immediate chunk encoder and its
// length calculator.
package imm_pkg;

    localparam int DATA_W     = 24;
    localparam int IMM_W      = 8;
    localparam int MAX_CHUNKS = DATA_W / IMM_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Chunk count / chunk index, wide enough for 1..3.
    typedef logic [1:0] len_t;

endpackage

// File: rtl/imm_len_calc.sv
// Combinational chunk-count estimator: smallest number of IMM_W chunks whose
// sign extension reproduces the DATA_W-bit signed value.
module imm_len_calc
    import imm_pkg::*;
#(
    parameter int DATA_W = imm_pkg::DATA_W,
    parameter int IMM_W  = imm_pkg::IMM_W
) (
    input  logic [DATA_W-1:0] value_i,
    output len_t              len_o
);

    localparam int MAX_CHUNKS = DATA_W / IMM_W;

    // k chunks suffice when bits [DATA_W-1 : k*IMM_W-1] are all copies of the sign.
    function automatic logic fits(input logic [DATA_W-1:0] v, input int k);
        logic signed [DATA_W-1:0] sh;
        sh = $signed(v) >>> (k * IMM_W - 1);
        return (sh == '0) || (&sh);
    endfunction

    always_comb begin
        len_o = len_t'(MAX_CHUNKS);
        for (int k = MAX_CHUNKS - 1; k >= 1; k--) begin
            if (fits(value_i, k)) begin
                len_o = len_t'(k);
            end
        end
    end

endmodule

// File: rtl/imm_chunk_encoder.sv
// Splits a signed constant into the shortest most-significant-first stream of
// IMM_W-bit immediates, with valid/ready on both sides and no inter-constant bubble.
module imm_chunk_encoder
    import imm_pkg::*;
#(
    parameter int DATA_W = imm_pkg::DATA_W,
    parameter int IMM_W  = imm_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_first,
    output logic              out_last,
    output logic [1:0]        out_len
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    len_t              len_q, len_d;
    len_t              idx_q, idx_d;
    len_t              in_len;
    logic              accept;

    imm_len_calc #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_len_calc (
        .value_i (in_value),
        .len_o   (in_len)
    );

    assign in_ready = (state_q == IDLE) ||
                      ((state_q == EMIT) && (idx_q == '0) && out_ready);
    assign accept   = in_valid && in_ready;

    // Outputs are decoded from registered state only, so they hold under backpressure.
    always_comb begin
        out_valid = 1'b0;
        out_imm   = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_len   = '0;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            out_imm   = val_q[idx_q * IMM_W +: IMM_W];
            out_first = (idx_q == (len_q - len_t'(1)));
            out_last  = (idx_q == '0);
            out_len   = len_q;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    val_d   = in_value;
                    len_d   = in_len;
                    idx_d   = in_len - len_t'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - len_t'(1);
                    end else if (accept) begin
                        val_d = in_value;
                        len_d = in_len;
                        idx_d = in_len - len_t'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Value register is only observed in EMIT, so it needs no reset.
    always_ff @(posedge clk) begin
        val_q <= val_d;
    end

endmodule
